// File: rtl/wb_gpio_irq.sv
// -----------------------------------------------------------------------------
// wb_gpio_irq
//   Wishbone B3 classic slave GPIO block: per-pin output value and direction,
//   two-flop synchronised pin inputs, and per-pin maskable edge/level
//   interrupts. Pin tristating is left to the SoC top.
//
// Build option:
//   WB_GPIO_IRQ_EN  defined   -> IE/EDGE/POL/STATUS registers and int_o exist.
//                   undefined -> those registers read 0, writes are dropped,
//                                the third synchroniser stage is removed and
//                                int_o is tied 0.
//
// Ports:
//   wb_clk_i, wb_rst_i         clock, synchronous active-high reset
//   wb_adr_i[4:0]              byte address, bits [4:2] select the register
//   wb_dat_i/wb_sel_i/wb_we_i  write data, byte enables, write strobe
//   wb_cyc_i/wb_stb_i          cycle / strobe
//   wb_cti_i/wb_bte_i          burst hints, ignored (all accesses classic)
//   wb_dat_o/wb_ack_o          registered read data and single-cycle ack
//   wb_err_o/wb_rty_o          always 0
//   gpio_i[WIDTH]              asynchronous pin inputs
//   gpio_o/gpio_dir_o[WIDTH]   OUT and DIR registers (1 = output)
//   int_o                      level interrupt, |(STATUS & IE)
//
// Register map (word offsets):
//   0x00 IN  0x04 OUT  0x08 DIR  0x0C IE  0x10 EDGE  0x14 POL
//   0x18 STATUS (W1C)  0x1C reserved
// -----------------------------------------------------------------------------
module wb_gpio_irq #(
  parameter int WIDTH = 32
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [4:0]       wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic [2:0]       wb_cti_i,
  input  logic [1:0]       wb_bte_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic             wb_rty_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_dir_o,
  output logic             int_o
);

  localparam logic [2:0] A_IN     = 3'd0;
  localparam logic [2:0] A_OUT    = 3'd1;
  localparam logic [2:0] A_DIR    = 3'd2;
`ifdef WB_GPIO_IRQ_EN
  localparam logic [2:0] A_IE     = 3'd3;
  localparam logic [2:0] A_EDGE   = 3'd4;
  localparam logic [2:0] A_POL    = 3'd5;
  localparam logic [2:0] A_STATUS = 3'd6;
`endif

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic             r_ack;
  logic [31:0]      r_dat;

  logic             w_access;
  logic             w_write;
  logic [2:0]       w_idx;
  logic [31:0]      w_bmask;
  logic [WIDTH-1:0] w_wmask;
  logic [WIDTH-1:0] w_wdata;
  logic [31:0]      w_rdata;
  logic             w_unused;

  // A held strobe must not be serviced on the cycle its ack is visible,
  // otherwise the master would see one ack for two register updates.
  assign w_access = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_write  = w_access & wb_we_i;
  assign w_idx    = wb_adr_i[4:2];
  assign w_bmask  = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                     {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign w_wmask  = w_bmask[WIDTH-1:0];
  assign w_wdata  = wb_dat_i[WIDTH-1:0] & w_wmask;

  assign w_unused = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0], wb_dat_i, w_bmask};

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old_v);
    return (old_v & ~w_wmask) | w_wdata;
  endfunction

`ifdef WB_GPIO_IRQ_EN
  logic [WIDTH-1:0] r_s3;
  logic [WIDTH-1:0] r_ie;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] r_pol;
  logic [WIDTH-1:0] r_status;
  logic [WIDTH-1:0] w_hit;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_status_nxt;

  assign w_hit = (r_pol & r_s2 & ~r_s3) | (~r_pol & ~r_s2 & r_s3);
  assign w_clr = (w_write && (w_idx == A_STATUS)) ? w_wdata : '0;

  // Edge pins: sticky, clear first so a coincident edge re-sets the bit.
  // Level pins: follow the pin every cycle, so a W1C is overwritten at once.
  assign w_status_nxt = (r_edge & ((r_status & ~w_clr) | w_hit)) |
                        (~r_edge & ~(r_s2 ^ r_pol));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_s3     <= '0;
      r_ie     <= '0;
      r_edge   <= '0;
      r_pol    <= '0;
      r_status <= '0;
    end else begin
      r_s3     <= r_s2;
      r_status <= w_status_nxt;
      if (w_write) begin
        if (w_idx == A_IE)   r_ie   <= merge(r_ie);
        if (w_idx == A_EDGE) r_edge <= merge(r_edge);
        if (w_idx == A_POL)  r_pol  <= merge(r_pol);
      end
    end
  end

  assign int_o = |(r_status & r_ie);
`else
  assign int_o = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      A_IN:     w_rdata[WIDTH-1:0] = r_s2;
      A_OUT:    w_rdata[WIDTH-1:0] = r_out;
      A_DIR:    w_rdata[WIDTH-1:0] = r_dir;
`ifdef WB_GPIO_IRQ_EN
      A_IE:     w_rdata[WIDTH-1:0] = r_ie;
      A_EDGE:   w_rdata[WIDTH-1:0] = r_edge;
      A_POL:    w_rdata[WIDTH-1:0] = r_pol;
      A_STATUS: w_rdata[WIDTH-1:0] = r_status;
`endif
      default:  w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_out <= '0;
      r_dir <= '0;
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_s1  <= gpio_i;
      r_s2  <= r_s1;
      r_ack <= w_access;
      r_dat <= w_access ? w_rdata : 32'd0;
      if (w_write) begin
        if (w_idx == A_OUT) r_out <= merge(r_out);
        if (w_idx == A_DIR) r_dir <= merge(r_dir);
      end
    end
  end

  assign wb_dat_o   = r_dat;
  assign wb_ack_o   = r_ack;
  assign wb_err_o   = 1'b0;
  assign wb_rty_o   = 1'b0;
  assign gpio_o     = r_out;
  assign gpio_dir_o = r_dir;

endmodule

// File: tb/tb_wb_gpio_irq.sv
module tb_wb_gpio_irq;

  localparam int W = 8;
`ifdef WB_GPIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  localparam logic [31:0] WMASK = 32'h0000_00FF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    adr = '0;
  logic [31:0]   dat_i = '0;
  logic [3:0]    sel = '0;
  logic          we = 1'b0;
  logic          cyc = 1'b0;
  logic          stb = 1'b0;
  logic [2:0]    cti = '0;
  logic [1:0]    bte = '0;
  logic [31:0]   dat_o;
  logic          ack;
  logic          err;
  logic          rty;
  logic [W-1:0]  gpio_in = '0;
  logic [W-1:0]  gpio_out;
  logic [W-1:0]  gpio_dir;
  logic          irq;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_gpio_irq #(.WIDTH(W)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_cti_i(cti), .wb_bte_i(bte), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .wb_err_o(err), .wb_rty_o(rty), .gpio_i(gpio_in), .gpio_o(gpio_out),
    .gpio_dir_o(gpio_dir), .int_o(irq)
  );

  // Reference model: register file as an array indexed by word offset,
  // pin history as a three-deep list of samples.
  logic [31:0]  m_reg [8];
  logic [W-1:0] m_s1, m_s2, m_s3;
  bit           m_ack;

  always @(posedge clk) begin
    logic [31:0] wm, wv, nst;
    bit acc, hit;
    int idx;
    if (rst) begin
      for (int r = 0; r < 8; r++) m_reg[r] = '0;
      m_s1 = '0; m_s2 = '0; m_s3 = '0; m_ack = 0;
    end else begin
      acc = cyc && stb && !m_ack;
      idx = int'(adr[4:2]);
      wm  = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}} & WMASK;
      wv  = dat_i & wm;
      nst = m_reg[6];
      for (int i = 0; i < W; i++) begin
        if (m_reg[4][i]) begin
          if (m_reg[5][i]) hit = (m_s2[i] == 1'b1) && (m_s3[i] == 1'b0);
          else             hit = (m_s2[i] == 1'b0) && (m_s3[i] == 1'b1);
          if (acc && we && idx == 6 && wv[i]) nst[i] = 1'b0;
          if (hit) nst[i] = 1'b1;
        end else begin
          nst[i] = (m_s2[i] == m_reg[5][i]);
        end
      end
      if (IRQ_EN) m_reg[6] = nst;
      if (acc && we) begin
        if (idx == 1 || idx == 2 || (IRQ_EN && idx >= 3 && idx <= 5))
          m_reg[idx] = (m_reg[idx] & ~wm) | wv;
      end
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = gpio_in;
      m_ack = acc;
    end
  end

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a[4:2] == 3'd0) return {24'd0, m_s2};
    if (a[4:2] == 3'd7) return 32'd0;
    return m_reg[a[4:2]];
  endfunction

  function automatic logic mint();
    return |(m_reg[6] & m_reg[3]);
  endfunction

  // Single classic access; returns what the bus did and what the model expected.
  task automatic xfer(input logic w, input logic [4:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd,
                      output logic [31:0] exp, output bit ok);
    logic pre;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; dat_i = d; sel = s;
    exp = mread(a);
    pre = ack;
    @(posedge clk); #1;
    ok = (pre === 1'b0) && (ack === 1'b1);
    rd = dat_o;
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd, exp;
    bit ok;
    xfer(1'b1, a, d, s, rd, exp, ok);
  endtask

  task automatic test_reset();
    logic [31:0] rd, exp, want;
    bit ok;
    repeat (3) @(negedge clk);
    rst = 0;
    n_cmp++; if (ack !== 1'b0 || dat_o !== 32'd0) begin n_fail++;
      $display("FAIL reset_bus: ack=%b dat=%h want 0/0", ack, dat_o); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++;
      $display("FAIL reset_int: got %b want 0", irq); end
    n_cmp++; if (gpio_dir !== '0 || gpio_out !== '0) begin n_fail++;
      $display("FAIL reset_pins: dir=%h out=%h want 0", gpio_dir, gpio_out); end
    for (int o = 0; o < 8; o++) begin
      xfer(1'b0, 5'(o * 4), 32'd0, 4'hF, rd, exp, ok);
      // With pins low and POL=0 every level-mode pin reports a match.
      want = (o == 6 && IRQ_EN) ? WMASK : 32'd0;
      n_cmp++; if (!ok) begin n_fail++;
        $display("FAIL reset_ack_%0d: ack not exactly one cycle after stb", o); end
      n_cmp++; if (rd !== want) begin n_fail++;
        $display("FAIL reset_read_%0d: got %h want %h", o, rd, want); end
    end
    n_cmp++; if (dat_o !== 32'd0) begin n_fail++;
      $display("FAIL idle_dat: got %h want 0", dat_o); end
  endtask

  task automatic test_bytelane();
    logic [31:0] rd, exp;
    bit ok;
    wr(5'h08, 32'hFFFF_FFFF, 4'b0001);
    n_cmp++; if (gpio_dir !== 8'hFF) begin n_fail++;
      $display("FAIL lane_dir: got %h want ff", gpio_dir); end
    xfer(1'b0, 5'h08, 32'd0, 4'hF, rd, exp, ok);
    n_cmp++; if (rd !== 32'h0000_00FF) begin n_fail++;
      $display("FAIL lane_dir_read: got %h want 000000ff", rd); end
    wr(5'h04, 32'h0000_00A5, 4'hF);
    n_cmp++; if (gpio_out !== 8'hA5) begin n_fail++;
      $display("FAIL lane_out: got %h want a5", gpio_out); end
    wr(5'h04, 32'hFFFF_FF5A, 4'b1110);
    n_cmp++; if (gpio_out !== 8'hA5) begin n_fail++;
      $display("FAIL lane_out_masked: got %h want a5", gpio_out); end
    wr(5'h00, 32'h0000_0077, 4'hF);
    xfer(1'b0, 5'h00, 32'd0, 4'hF, rd, exp, ok);
    n_cmp++; if (rd !== 32'd0) begin n_fail++;
      $display("FAIL in_readonly: got %h want 0", rd); end
  endtask

  task automatic test_rising_edge();
    logic [31:0] rd, exp, want;
    bit ok;
    wr(5'h14, 32'h1, 4'hF);
    wr(5'h10, 32'h1, 4'hF);
    wr(5'h0C, 32'h1, 4'hF);
    n_cmp++; if (irq !== 1'b0) begin n_fail++;
      $display("FAIL rise_idle_int: got %b want 0", irq); end
    xfer(1'b0, 5'h18, 32'd0, 4'hF, rd, exp, ok);
    want = IRQ_EN ? 32'hFE : 32'd0;
    n_cmp++; if (rd !== want) begin n_fail++;
      $display("FAIL rise_status0: got %h want %h", rd, want); end
    gpio_in[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b0) begin n_fail++;
      $display("FAIL rise_early: int at k+1 got %b want 0", irq); end
    @(posedge clk); #1;
    n_cmp++; if (irq !== IRQ_EN) begin n_fail++;
      $display("FAIL rise_k2: int got %b want %b", irq, IRQ_EN); end
    xfer(1'b0, 5'h18, 32'd0, 4'hF, rd, exp, ok);
    want = IRQ_EN ? 32'hFF : 32'd0;
    n_cmp++; if (rd !== want) begin n_fail++;
      $display("FAIL rise_status1: got %h want %h", rd, want); end
    wr(5'h18, 32'h1, 4'hF);
    n_cmp++; if (irq !== 1'b0) begin n_fail++;
      $display("FAIL rise_w1c: int got %b want 0", irq); end
  endtask

  task automatic test_collision();
    logic [31:0] rd, exp;
    bit ok;
    gpio_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_fail++;
      $display("FAIL coll_fall_ignored: int got %b want 0", irq); end
    gpio_in[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    wr(5'h18, 32'h1, 4'hF);
    n_cmp++; if (irq !== IRQ_EN) begin n_fail++;
      $display("FAIL coll_int: got %b want %b", irq, IRQ_EN); end
    xfer(1'b0, 5'h18, 32'd0, 4'hF, rd, exp, ok);
    n_cmp++; if (rd[0] !== IRQ_EN) begin n_fail++;
      $display("FAIL coll_status0: got %b want %b", rd[0], IRQ_EN); end
  endtask

  task automatic test_level();
    logic [31:0] rd, exp, want;
    bit ok;
    wr(5'h10, 32'h0, 4'hF);
    wr(5'h14, 32'h0, 4'hF);
    wr(5'h0C, 32'h2, 4'hF);
    n_cmp++; if (irq !== IRQ_EN) begin n_fail++;
      $display("FAIL level_int: got %b want %b", irq, IRQ_EN); end
    wr(5'h18, 32'h2, 4'hF);
    n_cmp++; if (irq !== IRQ_EN) begin n_fail++;
      $display("FAIL level_w1c: int got %b want %b", irq, IRQ_EN); end
    xfer(1'b0, 5'h18, 32'd0, 4'hF, rd, exp, ok);
    want = IRQ_EN ? 32'hFE : 32'd0;
    n_cmp++; if (rd !== want) begin n_fail++;
      $display("FAIL level_status: got %h want %h", rd, want); end
    gpio_in[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (irq !== IRQ_EN) begin n_fail++;
      $display("FAIL level_k1: int got %b want %b", irq, IRQ_EN); end
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b0) begin n_fail++;
      $display("FAIL level_k2: int got %b want 0", irq); end
  endtask

  task automatic test_back_to_back();
    bit want_ack;
    logic [31:0] want;
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 5'h08; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      want_ack = (i % 2 == 0);
      want = want_ack ? 32'hFF : 32'd0;
      n_cmp++; if (ack !== want_ack || dat_o !== want) begin n_fail++;
        $display("FAIL b2b_%0d: ack=%b dat=%h want %b/%h", i, ack, dat_o, want_ack, want); end
    end
    @(negedge clk);
    cyc = 0; stb = 0;
  endtask

  task automatic test_random();
    logic [31:0] rd, exp;
    logic [4:0] a;
    bit ok;
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 4))
        0, 1: begin
          gpio_in = 8'($urandom);
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        2: begin
          a = 5'($urandom_range(0, 7) * 4);
          xfer(1'b1, a, $urandom, 4'($urandom), rd, exp, ok);
          n_cmp++; if (!ok) begin n_fail++;
            $display("FAIL rnd_wr_ack: offset %h", a); end
        end
        3: begin
          a = 5'($urandom_range(0, 7) * 4);
          xfer(1'b0, a, 32'd0, 4'hF, rd, exp, ok);
          n_cmp++; if (!ok || rd !== exp) begin n_fail++;
            $display("FAIL rnd_rd: offset %h got %h want %h ack_ok %b", a, rd, exp, ok); end
        end
        default: wr(5'h18, $urandom, 4'hF);
      endcase
      n_cmp++; if (irq !== mint()) begin n_fail++;
        $display("FAIL rnd_int: it %0d got %b want %b", it, irq, mint()); end
      n_cmp++; if (gpio_out !== m_reg[1][W-1:0] || gpio_dir !== m_reg[2][W-1:0]) begin n_fail++;
        $display("FAIL rnd_pins: out %h dir %h want %h %h", gpio_out, gpio_dir,
                 m_reg[1][W-1:0], m_reg[2][W-1:0]); end
    end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd, exp;
    bit ok;
    wr(5'h04, 32'h3C, 4'hF);
    n_cmp++; if (gpio_out !== 8'h3C) begin n_fail++;
      $display("FAIL mid_pre: out got %h want 3c", gpio_out); end
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 5'h04; dat_i = 32'h99; sel = 4'hF; rst = 1;
    @(posedge clk); #1;
    n_cmp++; if (ack !== 1'b0 || gpio_out !== 8'h00) begin n_fail++;
      $display("FAIL mid_rst: ack=%b out=%h want 0/00", ack, gpio_out); end
    @(negedge clk);
    cyc = 0; stb = 0; we = 0; rst = 0;
    @(posedge clk); #1;
    n_cmp++; if (ack !== 1'b0 || irq !== 1'b0) begin n_fail++;
      $display("FAIL mid_after: ack=%b int=%b want 0/0", ack, irq); end
    xfer(1'b0, 5'h04, 32'd0, 4'hF, rd, exp, ok);
    n_cmp++; if (rd !== 32'd0) begin n_fail++;
      $display("FAIL mid_out_read: got %h want 0", rd); end
  endtask

  initial begin
    test_reset();
    test_bytelane();
    test_rising_edge();
    test_collision();
    test_level();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
